// File: rtl/wb_sram_arb2_if.sv
// Wishbone bus bundle used between the two requesters, the arbiter and the
// SRAM controller. One instance carries one Wishbone connection.
//
// Signals:
//   cyc, stb, we, tga   control, driven by the master
//   adr [adr_width]     word address, driven by the master
//   sel [2]             byte selects, driven by the master
//   dat_w [16]          write data, driven by the master
//   dat_r [16]          read data, driven by the slave
//   ack                 acknowledge, driven by the slave
//
// Modports:
//   master  the side that starts cycles
//   slave   the side that answers them
interface wb_sram_arb2_if #(
  parameter int adr_width = 19
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic                 tga;
  logic [adr_width-1:0] adr;
  logic [1:0]           sel;
  logic [15:0]          dat_w;
  logic [15:0]          dat_r;
  logic                 ack;

  modport master (
    output cyc, stb, we, tga, adr, sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, tga, adr, sel, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_sram_arb2.sv
// Two-master Wishbone arbiter in front of the single 16-bit SRAM controller.
// Master 0 is the CPU, master 1 a secondary requester such as video fetch or
// DMA. One master is granted at a time. Its cycle is routed to the SRAM
// controller, and only that master sees the acknowledge.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   m0     Wishbone slave port facing master 0
//   m1     Wishbone slave port facing master 1
//   s      Wishbone master port facing the SRAM controller
//   gnt    one-hot current grant: 01 = m0, 10 = m1, 00 = none
//
// Parameters:
//   adr_width  word-address width passed through
//   prio_mode  0 = round-robin, 1 = fixed priority with m0 always winning
//   max_burst  acks per grant (1..15) before a forced release, applied only
//              when the other master is waiting
module wb_sram_arb2 #(
  parameter int adr_width = 19,
  parameter int prio_mode = 0,
  parameter int max_burst = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_sram_arb2_if.slave    m0,
  wb_sram_arb2_if.slave    m1,
  wb_sram_arb2_if.master   s,
  output logic [1:0]       gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  logic                 last_gnt;     // 0 = m0 was granted last, 1 = m1
  logic [3:0]           burst_cnt;
  logic                 outstanding;

  logic                 req0;
  logic                 req1;
  logic                 granted;
  logic                 pick1;
  logic                 cur_cyc;
  logic                 cur_stb;
  logic                 other_req;
  logic                 burst_done;
  logic [adr_width-1:0] adr_mux;

  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;
  assign pick1   = (state == GNT1);
  assign granted = (state == GNT0) || (state == GNT1);

  assign cur_cyc   = pick1 ? m1.cyc : m0.cyc;
  assign cur_stb   = pick1 ? m1.stb : m0.stb;
  assign other_req = pick1 ? req0 : req1;

  // Widened by one bit so that the +1 cannot wrap when the counter has
  // saturated at 15.
  assign burst_done = ({1'b0, burst_cnt} + 5'd1) >= 5'(max_burst);

  // Slave side is a plain mux of the granted master. cyc/stb are forced low
  // outside a grant, which covers IDLE, DRAIN and the cycle after a release.
  assign adr_mux = pick1 ? m1.adr : m0.adr;
  assign s.adr   = adr_mux;
  assign s.dat_w = pick1 ? m1.dat_w : m0.dat_w;
  assign s.sel   = pick1 ? m1.sel   : m0.sel;
  assign s.we    = pick1 ? m1.we    : m0.we;
  assign s.tga   = pick1 ? m1.tga   : m0.tga;
  assign s.cyc   = granted & cur_cyc;
  assign s.stb   = granted & cur_cyc & cur_stb;

  // Read data fans out to both masters; the ack alone tells them apart.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = (state == GNT0) & s.ack;
  assign m1.ack   = (state == GNT1) & s.ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      last_gnt    <= 1'b1;
      burst_cnt   <= 4'd0;
      outstanding <= 1'b0;
    end else begin
      if (s.ack) begin
        outstanding <= 1'b0;
      end else if (s.stb) begin
        outstanding <= 1'b1;
      end

      if (s.ack && (burst_cnt != 4'hF)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          // m0 wins if it is alone, if m0 has fixed priority, or if m1 was
          // the last one served.
          if (req0 && (!req1 || (prio_mode != 0) || last_gnt)) begin
            state     <= GNT0;
            gnt       <= 2'b01;
            last_gnt  <= 1'b0;
            burst_cnt <= 4'd0;
          end else if (req1) begin
            state     <= GNT1;
            gnt       <= 2'b10;
            last_gnt  <= 1'b1;
            burst_cnt <= 4'd0;
          end
        end

        GNT0, GNT1: begin
          if (s.ack && burst_done && other_req) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end else if (!cur_cyc) begin
            // An ack in this very cycle completes the access, so only an
            // access that is still open needs draining.
            if (outstanding && !s.ack) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
            end
            gnt <= 2'b00;
          end
        end

        DRAIN: begin
          if (s.ack) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_arb2.sv
// Directed bench for wb_sram_arb2. Two arbiters are built side by side, one
// round-robin and one fixed-priority, and both receive the same master
// stimulus. Each arbiter has its own simple SRAM responder, which acks a
// configurable number of cycles after it sees a strobe and is not reset by
// the arbiter reset, so that a late ack can be observed.
`timescale 1ns/1ps
module tb_wb_sram_arb2;
  localparam int aw = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Master stimulus, shared by both arbiter instances
  logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [aw-1:0] m0_adr = '0;
  logic [1:0]    m0_sel = '0;
  logic [15:0]   m0_wdat = '0;
  logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [aw-1:0] m1_adr = '0;
  logic [1:0]    m1_sel = '0;
  logic [15:0]   m1_wdat = '0;

  // Per-instance observed outputs (index 0 = round-robin, 1 = fixed)
  logic [1:0]    gnt [2];
  logic          m0_ack [2];
  logic          m1_ack [2];
  logic [15:0]   m0_rdat [2];
  logic [15:0]   m1_rdat [2];
  logic          s_cyc [2];
  logic          s_stb [2];
  logic [aw-1:0] s_adr [2];
  logic [1:0]    s_sel [2];
  logic [15:0]   s_wdat [2];

  // SRAM responder state
  int          slave_lat = 1;
  logic [15:0] slave_rdata = 16'hBEEF;
  logic        sl_ack [2] = '{1'b0, 1'b0};
  logic        sl_busy [2] = '{1'b0, 1'b0};
  int          sl_cnt [2] = '{0, 0};

  for (genvar k = 0; k < 2; k++) begin : g
    wb_sram_arb2_if #(.adr_width(aw)) m0_bus ();
    wb_sram_arb2_if #(.adr_width(aw)) m1_bus ();
    wb_sram_arb2_if #(.adr_width(aw)) s_bus ();

    assign m0_bus.cyc   = m0_cyc;
    assign m0_bus.stb   = m0_stb;
    assign m0_bus.we    = m0_we;
    assign m0_bus.tga   = 1'b0;
    assign m0_bus.adr   = m0_adr;
    assign m0_bus.sel   = m0_sel;
    assign m0_bus.dat_w = m0_wdat;
    assign m1_bus.cyc   = m1_cyc;
    assign m1_bus.stb   = m1_stb;
    assign m1_bus.we    = m1_we;
    assign m1_bus.tga   = 1'b1;
    assign m1_bus.adr   = m1_adr;
    assign m1_bus.sel   = m1_sel;
    assign m1_bus.dat_w = m1_wdat;
    assign s_bus.ack    = sl_ack[k];
    assign s_bus.dat_r  = slave_rdata;

    assign m0_ack[k]  = m0_bus.ack;
    assign m1_ack[k]  = m1_bus.ack;
    assign m0_rdat[k] = m0_bus.dat_r;
    assign m1_rdat[k] = m1_bus.dat_r;
    assign s_cyc[k]   = s_bus.cyc;
    assign s_stb[k]   = s_bus.stb;
    assign s_adr[k]   = s_bus.adr;
    assign s_sel[k]   = s_bus.sel;
    assign s_wdat[k]  = s_bus.dat_w;

    wb_sram_arb2 #(
      .adr_width(aw),
      .prio_mode(k),
      .max_burst(4)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .m0   (m0_bus),
      .m1   (m1_bus),
      .s    (s_bus),
      .gnt  (gnt[k])
    );
  end

  // The responder samples a strobe, waits slave_lat cycles and then acks for
  // one cycle. The edge that ends an ack cycle never starts a new access.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sl_ack[k]) begin
        sl_ack[k] <= 1'b0;
      end else if (sl_busy[k]) begin
        if (sl_cnt[k] <= 1) begin
          sl_ack[k]  <= 1'b1;
          sl_busy[k] <= 1'b0;
        end else begin
          sl_cnt[k] <= sl_cnt[k] - 1;
        end
      end else if (s_cyc[k] && s_stb[k]) begin
        if (slave_lat <= 1) begin
          sl_ack[k] <= 1'b1;
        end else begin
          sl_busy[k] <= 1'b1;
          sl_cnt[k]  <= slave_lat - 1;
        end
      end
    end
  end

  // Every forwarded ack is logged with who received it and which write data
  // and byte selects were on the slave bus at that moment.
  logic [1:0]  who0 [$];
  logic [1:0]  who1 [$];
  logic [17:0] wr0 [$];
  logic [17:0] wr1 [$];
  always @(negedge clk) begin
    if (m0_ack[0] || m1_ack[0]) begin
      who0.push_back({m1_ack[0], m0_ack[0]});
      wr0.push_back({s_sel[0], s_wdat[0]});
    end
    if (m0_ack[1] || m1_ack[1]) begin
      who1.push_back({m1_ack[1], m0_ack[1]});
      wr1.push_back({s_sel[1], s_wdat[1]});
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [aw-1:0] adr,
                               input logic [1:0] sel, input logic [15:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we;
      m0_adr = adr; m0_sel = sel; m0_wdat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we;
      m1_adr = adr; m1_sel = sel; m1_wdat = dat;
    end
  endtask

  function automatic logic [1:0] whoAt(input int k, input int i);
    return (k == 0) ? who0[i] : who1[i];
  endfunction

  function automatic logic [17:0] wrAt(input int k, input int i);
    return (k == 0) ? wr0[i] : wr1[i];
  endfunction

  function automatic int logSize(input int k);
    return (k == 0) ? who0.size() : who1.size();
  endfunction

  // Waits a bounded time for instance 0 to deliver an ack, then lets the
  // master hold for the ack edge and drop its cycle, leaving the bus idle.
  task automatic finishAccess(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (m0_ack[0] || m1_ack[0]) seen = 1'b1;
    end
    checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int b[2];
    bit seen;
    logic [15:0] rd;
    logic [1:0]  ew;

    // Reset state
    $display("[TB] reset state");
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_gnt_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("rst_cyc_%0d", k), 32'(s_cyc[k]), 32'd0);
      checkOutput($sformatf("rst_stb_%0d", k), 32'(s_stb[k]), 32'd0);
      checkOutput($sformatf("rst_ack0_%0d", k), 32'(m0_ack[k]), 32'd0);
      checkOutput($sformatf("rst_ack1_%0d", k), 32'(m1_ack[k]), 32'd0);
    end
    reset = 1'b0;
    tick();

    // Single m0 read with a two-cycle SRAM
    $display("[TB] single m0 read");
    slave_lat   = 2;
    slave_rdata = 16'hBEEF;
    b[0] = logSize(0);
    b[1] = logSize(1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 19'h00123, 2'b11, 16'h0);
    checkOutput("rd_gnt_latency", 32'(gnt[0]), 32'd0);
    checkOutput("rd_stb_latency", 32'(s_stb[0]), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rd_gnt_%0d", k), 32'(gnt[k]), 32'h1);
      checkOutput($sformatf("rd_stb_%0d", k), 32'(s_stb[k]), 32'd1);
      checkOutput($sformatf("rd_adr_%0d", k), 32'(s_adr[k]), 32'h00123);
    end
    seen = 1'b0;
    rd   = 16'h0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (m0_ack[0]) begin
        seen = 1'b1;
        rd   = m0_rdat[0];
        checkOutput("rd_m1_ack", 32'(m1_ack[0]), 32'd0);
        checkOutput("rd_m1_dat", 32'(m1_rdat[0]), 32'hBEEF);
      end
    end
    checkOutput("rd_ack_seen", 32'(seen), 32'd1);
    checkOutput("rd_dat", 32'(rd), 32'hBEEF);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rd_release_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("rd_nacks_%0d", k), 32'(logSize(k) - b[k]), 32'd1);
      checkOutput($sformatf("rd_who_%0d", k), 32'(whoAt(k, b[k])), 32'h1);
    end

    // Both masters stream writes: instance 0 alternates every four acks,
    // instance 1 keeps m0 until m0 drops its cycle
    $display("[TB] competing writers");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    slave_lat = 1;
    b[0] = logSize(0);
    b[1] = logSize(1);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 19'h00010, 2'b01, 16'h1111);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 19'h00020, 2'b10, 16'h2222);
    repeat (27) tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    repeat (3) tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("wr_idle_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("wr_nacks_%0d", k), 32'(logSize(k) - b[k]), 32'd13);
      for (int j = 0; j < 13; j++) begin
        if (k == 0) ew = (j < 4 || (j >= 8 && j < 12)) ? 2'b01 : 2'b10;
        else        ew = (j < 12) ? 2'b01 : 2'b10;
        if (b[k] + j < logSize(k)) begin
          checkOutput($sformatf("wr_who_%0d_%0d", k, j), 32'(whoAt(k, b[k] + j)), 32'(ew));
          checkOutput($sformatf("wr_bus_%0d_%0d", k, j), 32'(wrAt(k, b[k] + j)),
                      (ew == 2'b01) ? 32'h1_1111 : 32'h2_2222);
        end
      end
    end

    // m1 aborts an open access; a waiting m0 is served after the drain
    $display("[TB] abort drain");
    slave_lat = 3;
    b[0] = logSize(0);
    b[1] = logSize(1);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 19'h00030, 2'b11, 16'h0);
    tick();
    checkOutput("ab_gnt1", 32'(gnt[0]), 32'h2);
    checkOutput("ab_stb", 32'(s_stb[0]), 32'd1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 19'h00040, 2'b11, 16'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("ab_drain_gnt_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("ab_drain_stb_%0d", k), 32'(s_stb[k]), 32'd0);
      checkOutput($sformatf("ab_drain_cyc_%0d", k), 32'(s_cyc[k]), 32'd0);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("ab_swallow0_%0d", k), 32'(m0_ack[k]), 32'd0);
      checkOutput($sformatf("ab_swallow1_%0d", k), 32'(m1_ack[k]), 32'd0);
    end
    tick();
    checkOutput("ab_idle", 32'(gnt[0]), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("ab_regrant_%0d", k), 32'(gnt[k]), 32'h1);
    end
    finishAccess("ab");
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("ab_nacks_%0d", k), 32'(logSize(k) - b[k]), 32'd1);
      checkOutput($sformatf("ab_who_%0d", k), 32'(whoAt(k, b[k])), 32'h1);
    end

    // Reset while an m0 read is open
    $display("[TB] reset mid read");
    slave_lat = 3;
    b[0] = logSize(0);
    b[1] = logSize(1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 19'h00050, 2'b11, 16'h0);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("mr_gnt_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("mr_stb_%0d", k), 32'(s_stb[k]), 32'd0);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("mr_late_ack0_%0d", k), 32'(m0_ack[k]), 32'd0);
      checkOutput($sformatf("mr_late_ack1_%0d", k), 32'(m1_ack[k]), 32'd0);
    end
    tick();
    slave_lat = 1;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 19'h00060, 2'b11, 16'h0);
    checkOutput("mr_post_latency", 32'(gnt[0]), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("mr_post_gnt_%0d", k), 32'(gnt[k]), 32'h1);
      checkOutput($sformatf("mr_post_adr_%0d", k), 32'(s_adr[k]), 32'h00060);
    end
    finishAccess("mr");
    checkOutput("mr_nacks", 32'(logSize(0) - b[0]), 32'd1);

    // Lone m0 runs ten back-to-back reads; the cap never releases it
    $display("[TB] lone burst");
    slave_lat = 1;
    b[0] = logSize(0);
    b[1] = logSize(1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 19'h00070, 2'b11, 16'h0);
    for (int i = 0; i < 21; i++) begin
      tick();
      checkOutput($sformatf("lb_gnt0_%0d", i), 32'(gnt[0]), 32'h1);
      checkOutput($sformatf("lb_gnt1_%0d", i), 32'(gnt[1]), 32'h1);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("lb_idle_%0d", k), 32'(gnt[k]), 32'd0);
      checkOutput($sformatf("lb_nacks_%0d", k), 32'(logSize(k) - b[k]), 32'd10);
      for (int j = 0; j < 10; j++) begin
        if (b[k] + j < logSize(k)) begin
          checkOutput($sformatf("lb_who_%0d_%0d", k, j), 32'(whoAt(k, b[k] + j)), 32'h1);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_sram_arb2.md
Name: wb_sram_arb2

Overview:
Two-master Wishbone arbiter that shares the single 16-bit SRAM controller between the CPU (master 0) and a secondary requester such as video fetch or DMA (master 1).
- Grants one master at a time and routes its cycle to the SRAM controller slave port.
- Returns ack and read data only to the granted master.
- Supports round-robin or fixed priority, with a cap on consecutive accesses per grant.
- Sits between the masters' Wishbone buses and the SRAM controller.

Parameters:
- adr_width, 19, Wishbone word-address width passed through.
- prio_mode, 0, 0 = round-robin; 1 = fixed priority with master 0 always winning.
- max_burst, 4, acks allowed per grant (1..15) before forced release if the other master is requesting.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i  in  1 each  master 0 Wishbone control
- m0_adr_i  in  adr_width  master 0 address
- m0_sel_i  in  2  master 0 byte selects
- m0_dat_i  in  16  master 0 write data
- m0_dat_o  out  16  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o, s_tga_o  out  1 each  to SRAM controller
- s_adr_o  out  adr_width  to SRAM controller
- s_sel_o  out  2  to SRAM controller
- s_dat_o  out  16  to SRAM controller
- s_dat_i  in  16  from SRAM controller
- s_ack_i  in  1  from SRAM controller
- gnt_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = none

Behaviour:
- Reset:
  - State is IDLE; gnt_o = 00.
  - last_gnt = m1, so m0 wins the first round-robin tie.
  - Burst counter = 0; outstanding flag = 0.
  - s_cyc_o = s_stb_o = 0; m0_ack_o = m1_ack_o = 0.
  - Reset mid-transaction aborts immediately; any late s_ack_i is ignored because no grant is held.
- States are IDLE, GNT0, GNT1 and DRAIN. gnt_o decodes the state.
- A master requests when mX_cyc_i & mX_stb_i.
- IDLE:
  - With no request, stay in IDLE.
  - With one requester, go to its GNT state.
  - With both requesting, prio_mode=1 picks m0; prio_mode=0 picks the master not equal to last_gnt.
  - On grant: last_gnt is updated and the burst counter is cleared.
  - The grant is registered, so s_stb_o first asserts the cycle after the request is seen in IDLE (1-cycle arbitration latency).
- GNTx slave outputs:
  - s_* outputs are a combinational mux of master x's signals.
  - s_dat_o, s_adr_o, s_sel_o, s_we_o and s_tga_o are muxed from master x.
  - s_cyc_o and s_stb_o are gated by the grant and by the release condition below.
- GNTx ack and data:
  - mx_ack_o = s_ack_i.
  - Both mX_dat_o are driven from s_dat_i; only the granted master sees an ack.
  - The non-granted master's ack is always 0.
- Outstanding flag: set on any cycle with s_stb_o=1 and s_ack_i=0; cleared on s_ack_i.
- Burst counter: increments on each s_ack_i; 4-bit and saturating.
- Release from GNTx:
  - (a) On an s_ack_i cycle where the counter+1 >= max_burst and the other master is requesting. s_stb_o is forced low in the following cycle; go to IDLE.
  - (b) When mx_cyc_i = 0 and the outstanding flag is clear: go to IDLE.
  - (c) When mx_cyc_i = 0 and the outstanding flag is set (master abort): go to DRAIN.
  - Otherwise hold the grant, including across idle gaps while cyc stays high.
- DRAIN: s_cyc_o = s_stb_o = 0; both acks are 0. Wait for s_ack_i, swallow it, then go to IDLE. The SRAM controller completes the started access regardless.
- The grant never changes while an access is outstanding.
- Single-cycle s_ack_i is assumed; a master must drop stb or present a new address after its ack.
- A request arriving in DRAIN or during release is served from IDLE next cycle; there is no lost request.

Test Plan:
- Single m0 read, m0 held: cyc/stb=1, adr=0x00123; slave model acks 2 cycles after s_stb_o with s_dat_i=0xBEEF -> gnt_o=01 one cycle later; m0_ack_o pulses once with m0_dat_o=0xBEEF; m1_ack_o stays 0.
- Simultaneous requests, prio_mode=0: both masters issue continuous single writes -> grants alternate m0, m1, m0 after max_burst (4) acks each; s_sel_o and s_dat_o track the granted master.
- Fixed priority, prio_mode=1: m0 requests continuously, m1 requests -> m1 is granted only when m0_cyc_i falls; the m0 burst cap is not enforced against m1 until m0 releases.
- Abort drain: m1 drops cyc the cycle after s_stb_o rises, before ack -> state DRAIN; s_stb_o=0; the following s_ack_i is not forwarded; gnt_o=00; a pending m0 request is granted the next cycle.
- Reset mid-read: assert reset while GNT0 is outstanding -> gnt_o=00, s_stb_o=0 on the next edge; a later s_ack_i produces no m0_ack_o; the first request after reset is granted normally.
- Burst cap with a lone requester: m0 performs 10 back-to-back reads, m1 idle -> no release; gnt_o stays 01 throughout; 10 acks are delivered.
